// File: rtl/tt_um_unload.sv
// Weight readback streamer: snapshots the parallel weight bus on start and
// replays it LSB chunk first as OUT_WIDTH-bit beats over a valid/ready port.
module tt_um_unload #(
  parameter int MAX_IN_LEN  = 16,
  parameter int MAX_OUT_LEN = 8,
  parameter int OUT_WIDTH   = 8,
  localparam int W     = 2 * MAX_IN_LEN * MAX_OUT_LEN,
  localparam int N     = W / OUT_WIDTH,
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ena,
  input  logic                 ui_start,
  input  logic [W-1:0]         ui_weights,
  input  logic                 ui_ready,
  output logic [OUT_WIDTH-1:0] uo_data,
  output logic                 uo_valid,
  output logic                 uo_last,
  output logic                 uo_busy,
  output logic                 uo_done
);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_DONE} state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  state_t                          state_q, state_d;
  logic [IDX_W-1:0]                idx_q, idx_d;
  // Beat-indexed view of the snapshot so the output mux is a plain array select.
  logic [N-1:0][OUT_WIDTH-1:0]     shadow_q, shadow_d;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    shadow_d = shadow_q;
    case (state_q)
      S_IDLE: begin
        if (ui_start) begin
          shadow_d = ui_weights;
          idx_d    = '0;
          state_d  = S_SEND;
        end
      end
      S_SEND: begin
        if (ui_ready) begin
          if (idx_q == LAST_IDX) state_d = S_DONE;
          else                   idx_d   = idx_q + IDX_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        idx_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        idx_d   = '0;
      end
    endcase
    // Disable overrides everything: abort silently, no done pulse.
    if (!ena) begin
      state_d = S_IDLE;
      idx_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      shadow_q <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
    end
  end

  // Outputs decode only registered state, so ui_ready never reaches them.
  always_comb begin
    uo_valid = (state_q == S_SEND);
    uo_busy  = (state_q == S_SEND);
    uo_done  = (state_q == S_DONE);
    uo_last  = (state_q == S_SEND) && (idx_q == LAST_IDX);
    uo_data  = (state_q == S_SEND) ? shadow_q[idx_q] : '0;
  end

endmodule
